// File: rtl/pla_div4_pkg.sv
// Shared types and constants for the iterative 8/4 restoring divider.
package pla_div4_pkg;

    localparam int unsigned DIVIDEND_W = 8;
    localparam int unsigned DIVISOR_W  = 4;
    localparam int unsigned ITER       = 8;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned PREM_W     = DIVISOR_W + 1;

    localparam logic [DIVIDEND_W-1:0] DZ_QUOTIENT  = 8'hFF;
    localparam logic [DIVISOR_W-1:0]  DZ_REMAINDER = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pla_div4_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the shifted value when the difference goes negative.
module pla_div4_step
    import pla_div4_pkg::*;
(
    input  logic [PREM_W-1:0]    rem_in,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [PREM_W-1:0]    rem_out_c,
    output logic                 q_bit_c
);

    logic [PREM_W:0] shifted_c;
    logic [PREM_W:0] diff_c;

    // One extra bit on top of the 5-bit partial remainder carries the borrow.
    always_comb begin
        shifted_c = {rem_in, dividend_bit};
        diff_c    = shifted_c - (PREM_W + 1)'(divisor);
        q_bit_c   = ~diff_c[PREM_W];
        rem_out_c = q_bit_c ? diff_c[PREM_W-1:0] : shifted_c[PREM_W-1:0];
    end

endmodule

// File: rtl/pla_div4.sv
// Iterative restoring divider (8-bit dividend / 4-bit divisor) with a
// valid/ready front and back. Define PLA_DIV4_RANGE_CHK_EN to flag quotients
// wider than 4 bits on ovf; otherwise ovf is tied low.
module pla_div4
    import pla_div4_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dz,
    output logic                  ovf
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] work_q;
    logic [PREM_W-1:0]     prem_q;
    logic [DIVISOR_W-1:0]  divisor_q;

    logic [PREM_W-1:0]     prem_nxt_c;
    logic                  q_bit_c;
    logic [DIVIDEND_W-1:0] quot_nxt_c;
    logic                  accept_c;
    logic                  last_iter_c;

    pla_div4_step u_step (
        .rem_in       (prem_q),
        .dividend_bit (work_q[DIVIDEND_W-1]),
        .divisor      (divisor_q),
        .rem_out_c    (prem_nxt_c),
        .q_bit_c      (q_bit_c)
    );

    // work_q shifts dividend bits out of the top and quotient bits in at the bottom.
    assign quot_nxt_c  = {work_q[DIVIDEND_W-2:0], q_bit_c};
    assign accept_c    = in_valid & in_ready;
    assign last_iter_c = (cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            work_q    <= '0;
            prem_q    <= '0;
            divisor_q <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        in_ready  <= 1'b0;
                        cnt       <= '0;
                        work_q    <= dividend;
                        prem_q    <= '0;
                        divisor_q <= divisor;
                        if (divisor == '0) begin
                            state     <= DONE;
                            quotient  <= DZ_QUOTIENT;
                            remainder <= DZ_REMAINDER;
                            dz        <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt    <= cnt + CNT_W'(1);
                    work_q <= quot_nxt_c;
                    prem_q <= prem_nxt_c;
                    if (last_iter_c) begin
                        state     <= DONE;
                        quotient  <= quot_nxt_c;
                        remainder <= prem_nxt_c[DIVISOR_W-1:0];
                        dz        <= 1'b0;
                    end
                end
                DONE: begin
                    // Result registers settle on entry; valid follows one cycle later.
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLA_DIV4_RANGE_CHK_EN
    logic ovf_q;

    // A quotient above 4 bits means the dividend is not a 4x4 product of this divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == CALC && last_iter_c) begin
            ovf_q <= |quot_nxt_c[DIVIDEND_W-1:DIVISOR_W];
        end else if (state == IDLE && accept_c && divisor == '0) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pla_div4.sv
// Self-checking bench for pla_div4: directed cases plus randomized operations
// scored against an arithmetic division model.
module tb_pla_div4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dz;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;

    pla_div4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division.
    function automatic logic [7:0] exp_q(int a, int b);
        if (b == 0) return 8'hFF;
        return 8'(a / b);
    endfunction

    function automatic logic [3:0] exp_r(int a, int b);
        if (b == 0) return 4'hF;
        return 4'(a % b);
    endfunction

    function automatic logic exp_ovf(int a, int b);
`ifdef PLA_DIV4_RANGE_CHK_EN
        return (b != 0) && ((a / b) > 15);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(int b);
        return (b == 0) ? 1 : 9;
    endfunction

    // Drives one full transaction; garbage operands are offered while busy.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int stall,
                          output int lat, output logic [7:0] q, output logic [3:0] r,
                          output logic dzo, output logic ovfo, output logic stable,
                          output logic rdy_after, output logic vld_after);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        stable   = 1'b1;
        q = quotient; r = remainder; dzo = dz; ovfo = ovf;
        if (!out_valid) begin
            lat = -1;
            rdy_after = 1'b0;
            vld_after = 1'b1;
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!out_valid || quotient !== q || remainder !== r || dz !== dzo || ovf !== ovfo)
                stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        rdy_after = in_ready;
        vld_after = out_valid;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, quotient, remainder, dz, ovf} !== 15'd0)
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, quotient, remainder, dz, ovf});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_op(input string name, input logic [7:0] a, input logic [3:0] b, input int stall);
        int lat; logic [7:0] q; logic [3:0] r; logic d, o, st, rdy, vld;
        run_op(a, b, stall, lat, q, r, d, o, st, rdy, vld);
        n_checks++;
        if (lat !== exp_lat(b)) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(b));
        else n_pass++;
        n_checks++;
        if (q !== exp_q(a, b)) $display("FAIL %s quotient: got %0d expected %0d", name, q, exp_q(a, b));
        else n_pass++;
        n_checks++;
        if (r !== exp_r(a, b)) $display("FAIL %s remainder: got %0d expected %0d", name, r, exp_r(a, b));
        else n_pass++;
        n_checks++;
        if (d !== (b == 0)) $display("FAIL %s dz: got %b expected %b", name, d, (b == 0));
        else n_pass++;
        n_checks++;
        if (o !== exp_ovf(a, b)) $display("FAIL %s ovf: got %b expected %b", name, o, exp_ovf(a, b));
        else n_pass++;
        n_checks++;
        if (st !== 1'b1) $display("FAIL %s stable: got %b expected 1", name, st);
        else n_pass++;
        n_checks++;
        if ({rdy, vld} !== 2'b10) $display("FAIL %s post_handshake in_ready/out_valid: got %b expected 10", name, {rdy, vld});
        else n_pass++;
    endtask

    task automatic test_basic;
        test_op("div_143_11", 8'd143, 4'd11, 0);
    endtask

    task automatic test_range;
        test_op("div_200_3", 8'd200, 4'd3, 0);
    endtask

    task automatic test_div_zero;
        test_op("div_37_0", 8'd37, 4'd0, 0);
    endtask

    task automatic test_backpressure;
        test_op("div_225_15_stall", 8'd225, 4'd15, 5);
    endtask

    task automatic test_reset_mid_calc;
        bit seen;
        dividend = 8'd100; divisor = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, quotient, remainder, dz, ovf} !== 15'd0)
            $display("FAIL midcalc_async_reset: got %h expected 0", {out_valid, quotient, remainder, dz, ovf});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL midcalc_no_result: got out_valid 1 expected 0");
        else n_pass++;
        test_op("div_100_7_after_reset", 8'd100, 4'd7, 0);
    endtask

    task automatic test_sweep;
        int lat; logic [7:0] q; logic [3:0] r; logic d, o, st, rdy, vld;
        int bad;
        bad = 0;
        for (int a = 1; a <= 15; a++) begin
            for (int b = 1; b <= 15; b++) begin
                for (int rr = 0; rr < b; rr++) begin
                    run_op(8'(a * b + rr), 4'(b), 0, lat, q, r, d, o, st, rdy, vld);
                    n_checks++;
                    if (q !== 8'(a) || r !== 4'(rr) || o !== 1'b0 || d !== 1'b0 || lat !== 9) begin
                        if (bad < 10)
                            $display("FAIL sweep %0d/%0d: got q=%0d r=%0d ovf=%b dz=%b lat=%0d expected q=%0d r=%0d ovf=0 dz=0 lat=9",
                                     a * b + rr, b, q, r, o, d, lat, a, rr);
                        bad++;
                    end else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random;
        int lat; logic [7:0] q; logic [3:0] r; logic d, o, st, rdy, vld;
        logic [7:0] a; logic [3:0] b; int stall;
        for (int n = 0; n < 150; n++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            stall = $urandom_range(0, 3);
            run_op(a, b, stall, lat, q, r, d, o, st, rdy, vld);
            n_checks++;
            if (q !== exp_q(a, b) || r !== exp_r(a, b) || d !== (b == 0) || o !== exp_ovf(a, b)
                || lat !== exp_lat(b) || st !== 1'b1 || {rdy, vld} !== 2'b10)
                $display("FAIL random %0d/%0d: got q=%0d r=%0d dz=%b ovf=%b lat=%0d stable=%b expected q=%0d r=%0d dz=%b ovf=%b lat=%0d stable=1",
                         a, b, q, r, d, o, lat, st, exp_q(a, b), exp_r(a, b), (b == 0), exp_ovf(a, b), exp_lat(b));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_range;
        test_div_zero;
        test_backpressure;
        test_reset_mid_calc;
        test_sweep;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
